// File: rtl/wb_arb_pkg.sv
// Shared types for the writeback port arbiter: FSM state, queued MDU entry, counter sizing.
// Optional starvation-forced drain is enabled with WB_ARB_STARVE_EN.
package wb_arb_pkg;

  localparam int unsigned WB_DATA_W = 32;
  localparam int unsigned WB_ADDR_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    FORCE = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] rd;
    logic [WB_DATA_W-1:0] data;
  } entry_t;

  function automatic int unsigned starve_cnt_w(input int unsigned limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/wb_arb_fifo.sv
// Circular queue of MDU results awaiting a register-file write slot.
// Exposes the head entry, occupancy and a flat valid/rd view for hazard lookups.
module wb_arb_fifo
  import wb_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  entry_t                      push_entry,
  input  logic                        pop,
  output entry_t                      head_c,
  output logic                        full_c,
  output logic                        empty_c,
  output logic [CNT_W-1:0]            count_c,
  output logic [DEPTH-1:0]            vld_c,
  output logic [DEPTH*WB_ADDR_W-1:0]  rds_c
);

  entry_t           mem_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] vld_d;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_ok;
  logic             pop_ok;

  assign full_c  = (count_q == CNT_W'(DEPTH));
  assign empty_c = (count_q == '0);
  assign push_ok = push & ~full_c;
  assign pop_ok  = pop & ~empty_c;
  assign count_c = count_q;
  assign head_c  = mem_q[rd_ptr_q];
  assign vld_c   = vld_q;

  for (genvar i = 0; i < DEPTH; i++) begin : g_rds
    assign rds_c[i*WB_ADDR_W +: WB_ADDR_W] = mem_q[i].rd;
  end

  // Per-slot valid tracking; push and pop never target the same slot.
  always_comb begin
    vld_d = vld_q;
    if (pop_ok)  vld_d[rd_ptr_q] = 1'b0;
    if (push_ok) vld_d[wr_ptr_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      vld_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
      vld_q   <= vld_d;
    end
  end

  // Payload storage needs no reset; validity is carried by vld_q.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_entry;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the Writeback stage and queued MDU results.
// Define WB_ARB_STARVE_EN to add the starvation counter and forced-drain (FORCE) state.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned ADDR_WIDTH   = 5,
  parameter int unsigned FIFO_DEPTH   = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RegWriteW,
  input  logic [ADDR_WIDTH-1:0] RdW,
  input  logic [WIDTH-1:0]      ResultW,
  input  logic                  mdu_valid,
  output logic                  mdu_ready,
  input  logic [ADDR_WIDTH-1:0] mdu_rd,
  input  logic [WIDTH-1:0]      mdu_data,
  output logic                  stall_w,
  output logic                  rf_we,
  output logic [ADDR_WIDTH-1:0] rf_addr,
  output logic [WIDTH-1:0]      rf_wdata,
  input  logic [ADDR_WIDTH-1:0] q_addr,
  output logic                  pend_hit
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  // Queue entries use the package widths, so the port widths must agree with them.
  if (WIDTH != WB_DATA_W || ADDR_WIDTH != WB_ADDR_W) begin : g_bad_width
    $error("wb_port_arbiter: WIDTH/ADDR_WIDTH must match wb_arb_pkg entry widths");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("wb_port_arbiter: FIFO_DEPTH must be a power of two >= 2");
  end
  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("wb_port_arbiter: STARVE_LIMIT must be >= 1");
  end

  arb_state_e                  state_q;
  arb_state_e                  state_d;
  entry_t                      push_entry;
  entry_t                      head_c;
  logic                        full_c;
  logic                        empty_c;
  logic [CNT_W-1:0]            count_c;
  logic [FIFO_DEPTH-1:0]       vld_c;
  logic [FIFO_DEPTH*WB_ADDR_W-1:0] rds_c;
  logic                        push_c;
  logic                        pop_c;
  logic                        last_pop_c;

`ifdef WB_ARB_STARVE_EN
  localparam int unsigned SC_W = starve_cnt_w(STARVE_LIMIT);
  logic [SC_W-1:0] starve_q;
  logic [SC_W-1:0] starve_d;
`endif

  assign mdu_ready       = rst & ~full_c;
  assign push_c          = mdu_valid & mdu_ready;
  assign push_entry.rd   = mdu_rd;
  assign push_entry.data = mdu_data;
  // This pop takes the last entry and nothing refills it this cycle.
  assign last_pop_c      = pop_c && (count_c == CNT_W'(1)) && !push_c;

  wb_arb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push_c),
    .push_entry (push_entry),
    .pop        (pop_c),
    .head_c     (head_c),
    .full_c     (full_c),
    .empty_c    (empty_c),
    .count_c    (count_c),
    .vld_c      (vld_c),
    .rds_c      (rds_c)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
`ifdef WB_ARB_STARVE_EN
      starve_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
`ifdef WB_ARB_STARVE_EN
      starve_q <= starve_d;
`endif
    end
  end

  // Next state: track occupancy, count denied head cycles, escalate to FORCE.
  always_comb begin
    state_d = state_q;
`ifdef WB_ARB_STARVE_EN
    starve_d = starve_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (push_c) state_d = PEND;
      end
      PEND: begin
        if (pop_c) begin
          state_d = last_pop_c ? IDLE : PEND;
`ifdef WB_ARB_STARVE_EN
          starve_d = '0;
`endif
        end
`ifdef WB_ARB_STARVE_EN
        else if (starve_q == SC_W'(STARVE_LIMIT - 1)) begin
          state_d  = FORCE;
          starve_d = '0;
        end else begin
          starve_d = starve_q + SC_W'(1);
        end
`endif
      end
      FORCE: begin
        state_d = last_pop_c ? IDLE : PEND;
`ifdef WB_ARB_STARVE_EN
        starve_d = '0;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant mux: forced drain, then pipeline, then idle-slot drain.
  always_comb begin
    pop_c    = 1'b0;
    stall_w  = 1'b0;
    rf_we    = 1'b0;
    rf_addr  = RdW;
    rf_wdata = ResultW;
`ifdef WB_ARB_STARVE_EN
    if (state_q == FORCE) begin
      pop_c    = ~empty_c;
      stall_w  = 1'b1;
      rf_we    = |head_c.rd;
      rf_addr  = head_c.rd;
      rf_wdata = head_c.data;
    end else
`endif
    if (RegWriteW) begin
      rf_we = |RdW;
    end else if (!empty_c) begin
      pop_c    = 1'b1;
      rf_we    = |head_c.rd;
      rf_addr  = head_c.rd;
      rf_wdata = head_c.data;
    end
    if (!rst) rf_we = 1'b0;
  end

  // Hazard lookup against every queued destination; x0 never matches.
  always_comb begin
    pend_hit = 1'b0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      if (vld_c[i] && (rds_c[i*WB_ADDR_W +: WB_ADDR_W] == q_addr)) pend_hit = 1'b1;
    end
    pend_hit = pend_hit & (|q_addr);
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter; expectations follow the build's WB_ARB_STARVE_EN setting.
module tb_wb_port_arbiter;

  typedef struct {
    int          cyc;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        stall;
  } exp_t;

`ifdef WB_ARB_STARVE_EN
  localparam bit STARVE_ON = 1'b1;
`else
  localparam bit STARVE_ON = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        RegWriteW;
  logic [4:0]  RdW;
  logic [31:0] ResultW;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_data;
  logic        stall_w;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_wdata;
  logic [4:0]  q_addr;
  logic        pend_hit;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];

  wb_port_arbiter #(
    .WIDTH        (32),
    .ADDR_WIDTH   (5),
    .FIFO_DEPTH   (2),
    .STARVE_LIMIT (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .RegWriteW (RegWriteW),
    .RdW       (RdW),
    .ResultW   (ResultW),
    .mdu_valid (mdu_valid),
    .mdu_ready (mdu_ready),
    .mdu_rd    (mdu_rd),
    .mdu_data  (mdu_data),
    .stall_w   (stall_w),
    .rf_we     (rf_we),
    .rf_addr   (rf_addr),
    .rf_wdata  (rf_wdata),
    .q_addr    (q_addr),
    .pend_hit  (pend_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic expect_wr(input int c, input logic [4:0] a, input logic [31:0] d, input logic s);
    exp_t e;
    e.cyc = c;
    e.addr = a;
    e.data = d;
    e.stall = s;
    exp_q.push_back(e);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, exp);
    end
  endtask

  // Every register-file write is matched against the next expected write.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rf_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write at cycle %0d: addr=%0d data=%h stall=%b, expected no write",
                 cyc, rf_addr, rf_wdata, stall_w);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || rf_addr !== e.addr || rf_wdata !== e.data || stall_w !== e.stall) begin
          failures++;
          $display("FAIL write_c%0d: got cyc=%0d addr=%0d data=%h stall=%b, expected cyc=%0d addr=%0d data=%h stall=%b",
                   e.cyc, cyc, rf_addr, rf_wdata, stall_w, e.cyc, e.addr, e.data, e.stall);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; RegWriteW = 1'b1; RdW = 5'd3; ResultW = 32'h33;
    mdu_valid = 1'b0; mdu_rd = '0; mdu_data = '0; q_addr = '0;

    // Reset held with a pipeline write pending.
    repeat (2) step();
    settle();
    chk1("rst_rf_we", rf_we, 1'b0);
    chk1("rst_mdu_ready", mdu_ready, 1'b0);
    chk1("rst_stall_w", stall_w, 1'b0);
    chk1("rst_pend_hit", pend_hit, 1'b0);
    step(); rst = 1'b1; expect_wr(cyc, 5'd3, 32'h33, 1'b0);
    settle();
    chk1("post_rst_ready", mdu_ready, 1'b1);

    // Single MDU result retires one cycle after push.
    step(); RegWriteW = 1'b0; mdu_valid = 1'b1; mdu_rd = 5'd5; mdu_data = 32'hDEAD;
    expect_wr(cyc + 1, 5'd5, 32'hDEAD, 1'b0);
    step(); mdu_valid = 1'b0;
    step();
    settle();
    chk1("idle_no_write", rf_we, 1'b0);

    // Continuous pipeline writes against a queued result.
    step(); mdu_valid = 1'b1; mdu_rd = 5'd7; mdu_data = 32'h77;
    for (int k = 1; k <= 6; k++) begin
      step();
      mdu_valid = 1'b0; RegWriteW = 1'b1;
      RdW = 5'(10 + ((k == 6) ? 5 : k));
      ResultW = 32'h1000 + 32'((k == 6) ? 5 : k);
`ifdef WB_ARB_STARVE_EN
      if (k == 5) expect_wr(cyc, 5'd7, 32'h77, 1'b1);
      else        expect_wr(cyc, RdW, ResultW, 1'b0);
`else
      expect_wr(cyc, RdW, ResultW, 1'b0);
`endif
      settle();
      chk1($sformatf("stall_k%0d", k), stall_w, STARVE_ON && (k == 5));
    end
    step(); RegWriteW = 1'b0;
`ifndef WB_ARB_STARVE_EN
    expect_wr(cyc, 5'd7, 32'h77, 1'b0);
`endif

    // Fill the queue, hold a third result under backpressure.
    step(); mdu_valid = 1'b1; mdu_rd = 5'd17; mdu_data = 32'hA;
    RegWriteW = 1'b1; RdW = 5'd21; ResultW = 32'h2100; expect_wr(cyc, 5'd21, 32'h2100, 1'b0);
    step(); mdu_rd = 5'd18; mdu_data = 32'hB;
    RdW = 5'd22; ResultW = 32'h2200; expect_wr(cyc, 5'd22, 32'h2200, 1'b0);
    settle();
    chk1("ready_one_entry", mdu_ready, 1'b1);
    step(); mdu_rd = 5'd19; mdu_data = 32'hC;
    RdW = 5'd23; ResultW = 32'h2300; expect_wr(cyc, 5'd23, 32'h2300, 1'b0);
    settle();
    chk1("ready_full", mdu_ready, 1'b0);
    step(); RegWriteW = 1'b0; expect_wr(cyc, 5'd17, 32'hA, 1'b0);
    settle();
    chk1("ready_full_pop_cycle", mdu_ready, 1'b0);
    step(); expect_wr(cyc, 5'd18, 32'hB, 1'b0);
    settle();
    chk1("ready_after_pop", mdu_ready, 1'b1);
    step(); mdu_valid = 1'b0; expect_wr(cyc, 5'd19, 32'hC, 1'b0);

    // Hazard lookup on a queued destination.
    step(); mdu_valid = 1'b1; mdu_rd = 5'd9; mdu_data = 32'h99; q_addr = 5'd9;
    RegWriteW = 1'b1; RdW = 5'd2; ResultW = 32'h200; expect_wr(cyc, 5'd2, 32'h200, 1'b0);
    settle();
    chk1("hit_before_queue", pend_hit, 1'b0);
    step(); mdu_valid = 1'b0; expect_wr(cyc, 5'd2, 32'h200, 1'b0);
    settle();
    chk1("hit_queued", pend_hit, 1'b1);
    step(); q_addr = 5'd0; expect_wr(cyc, 5'd2, 32'h200, 1'b0);
    settle();
    chk1("hit_qaddr_zero", pend_hit, 1'b0);
    step(); q_addr = 5'd4; RegWriteW = 1'b0; expect_wr(cyc, 5'd9, 32'h99, 1'b0);
    settle();
    chk1("hit_other_addr", pend_hit, 1'b0);
    step(); q_addr = 5'd9;
    settle();
    chk1("hit_after_drain", pend_hit, 1'b0);

    // x0 destination is consumed without a write, then the next entry follows.
    step(); mdu_valid = 1'b1; mdu_rd = 5'd0; mdu_data = 32'h1; q_addr = 5'd0;
    step(); mdu_rd = 5'd6; mdu_data = 32'h66;
    settle();
    chk1("rd0_no_we", rf_we, 1'b0);
    step(); mdu_valid = 1'b0; expect_wr(cyc, 5'd6, 32'h66, 1'b0);
    step();
    settle();
    chk1("rd0_drained_we", rf_we, 1'b0);
    chk1("rd0_drained_ready", mdu_ready, 1'b1);

    // Reset mid-operation discards the queued result.
    step(); mdu_valid = 1'b1; mdu_rd = 5'd20; mdu_data = 32'h2020;
    RegWriteW = 1'b1; RdW = 5'd24; ResultW = 32'h2400; expect_wr(cyc, 5'd24, 32'h2400, 1'b0);
    step(); mdu_valid = 1'b0; q_addr = 5'd20; expect_wr(cyc, 5'd24, 32'h2400, 1'b0);
    settle();
    chk1("hit_before_reset", pend_hit, 1'b1);
    step(); rst = 1'b0;
    settle();
    chk1("midrst_pend_hit", pend_hit, 1'b0);
    chk1("midrst_ready", mdu_ready, 1'b0);
    chk1("midrst_rf_we", rf_we, 1'b0);
    step(); rst = 1'b1; RegWriteW = 1'b0;
    repeat (3) step();
    settle();
    chk1("postrst_pend_hit", pend_hit, 1'b0);
    chk1("postrst_stall_w", stall_w, 1'b0);

    step();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drained: %0d expected writes never seen, expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
